// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer
// Read-side controller for the scratch SRAM. A start command issues `len`
// sequential reads from `base_addr` (wrapping at the top of the array). The
// returned words are streamed out on a valid/ready master port. A 2-entry
// FIFO hides the one-cycle registered read latency and absorbs downstream
// backpressure. Reads are credit-gated so the FIFO can never overflow.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; only state in which start is accepted
// RUN    | issuing reads while credit allows, until all len are issued
// DRAIN  | all reads issued; waiting for the last beat to handshake
// DONE   | one-cycle completion pulse, then back to IDLE
module sram_rd_streamer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 192
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              csbn,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_m1;
    logic [ADDR_W:0]   rd_cnt_q;
    logic [ADDR_W:0]   out_cnt_q;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              accept;
    logic              push;
    logic              pop;
    logic [2:0]        occupancy;
    logic              credit_ok;
    logic              rd_issue;
    logic              last_issue;

    // Handshake and credit bookkeeping. A read may be issued only if the FIFO
    // plus the word already in flight, minus what leaves this cycle, still
    // leaves room for it when it lands.
    assign accept     = (state_q == S_IDLE) && start;
    assign pop        = m_valid && m_ready;
    assign push       = inflight_q;
    assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign credit_ok  = occupancy < (3'd2 + {2'b00, pop});
    assign len_m1     = len_q - CNT_ONE;
    assign rd_issue   = (state_q == S_RUN) && (rd_cnt_q < len_q) && credit_ok;
    assign last_issue = rd_issue && (rd_cnt_q == len_m1);

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs and SRAM read port
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        csbn  = ~rd_issue;
        raddr = base_q + rd_cnt_q[ADDR_W-1:0];
    end

    // Command registers and read/beat counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q     <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (accept) begin
                base_q    <= base_addr;
                len_q     <= len;
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (rd_issue) begin
                    rd_cnt_q <= rd_cnt_q + CNT_ONE;
                end
                if (pop) begin
                    out_cnt_q <= out_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Two-entry output FIFO; rdata is captured only in the cycle after a read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= rdata;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Stream side: head of FIFO; last flag from the index of the head word
    assign m_valid = (fifo_cnt_q != 2'd0);
    assign m_data  = fifo_mem[rd_ptr_q];
    assign m_last  = m_valid && (out_cnt_q == len_m1);

    // The credit check must make a push into a full FIFO impossible
    a_fifo_no_overrun: assert property (
        @(posedge clk) disable iff (!rstn) push |-> (fifo_cnt_q != 2'd2)
    );

endmodule

// File: tb/tb_sram_rd_streamer.sv
module tb_sram_rd_streamer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 192;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy;
    logic              done;
    logic              csbn;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    sram_rd_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .csbn      (csbn),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model: registered read, garbage when not reading
    logic [DATA_W-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (csbn == 1'b0) rdata <= mem[raddr];
        else rdata <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic [ADDR_W-1:0] exp_addr_q [$];
    beat_t             exp_beat_q [$];

    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    int n_popped = 0;
    int max_out = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares reads and beats against the expected queues
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (csbn === 1'b0) begin
                n_issued++;
                if (exp_addr_q.size() == 0) fail_now("unexpected_read");
                else chk("raddr", raddr, exp_addr_q.pop_front());
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                beat_t b;
                n_popped++;
                if (exp_beat_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    b = exp_beat_q.pop_front();
                    chk("beat_data", m_data, b.data);
                    chk("beat_last", m_last, b.last);
                end
            end
            if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 5) == 0) || ((c % 5) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic push_expected(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        logic [ADDR_W-1:0] a;
        beat_t             bt;
        exp_addr_q.delete();
        exp_beat_q.delete();
        for (int k = 0; k < int'(l); k++) begin
            a       = b + k[ADDR_W-1:0];
            bt.data = mem[a];
            bt.last = (k == int'(l) - 1);
            exp_addr_q.push_back(a);
            exp_beat_q.push_back(bt);
        end
        n_issued = 0;
        n_popped = 0;
        max_out  = 0;
    endtask

    // Issue one command in the current cycle (cycle 0) and run it to done
    task automatic run_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                           input int mode, input int restart_cyc);
        int got_done = -1;
        int first_rd = -1;
        int first_v  = -1;
        int nrd      = 0;
        int limit;
        limit = 6 * int'(l) + 20;
        push_expected(b, l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        m_ready   = ready_for(mode, 0);
        @(posedge clk); #1;
        for (int c = 1; c <= limit; c++) begin
            if (c == restart_cyc) begin
                start     = 1'b1;
                base_addr = b + 12'd100;
                len       = 13'd7;
            end else begin
                start = 1'b0;
            end
            m_ready = ready_for(mode, c);
            @(negedge clk);
            if (c == 1) chk("busy_cycle1", busy, 1);
            if (csbn == 1'b0) begin
                nrd++;
                if (first_rd < 0) first_rd = c;
            end
            if (m_valid && first_v < 0) first_v = c;
            if (done) got_done = c;
            @(posedge clk); #1;
            if (got_done >= 0) break;
        end
        start = 1'b0;
        if (got_done < 0) begin
            fail_now("done_timeout");
        end else begin
            if (mode == 0) chk("done_cycle", got_done, (l == 0) ? 1 : int'(l) + 3);
            chk("busy_after_done", busy, 0);
        end
        chk("read_count", nrd, int'(l));
        chk("beats_left", exp_beat_q.size(), 0);
        chk("max_outstanding_over_2", (max_out > 2), 0);
        if (l == 0) chk("len0_no_valid", first_v, -1);
        if (mode == 0 && l != 0) begin
            chk("first_read_cycle", first_rd, 1);
            chk("first_valid_cycle", first_v, 3);
        end
    endtask

    initial begin
        logic [11:0] t;
        for (int i = 0; i < 4096; i++) begin
            t = i[11:0];
            mem[i] = {16{t}};
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_csbn", csbn, 1);
        chk("rst_raddr", raddr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        run_cmd(12'd10,   13'd4, 0, 0);   // basic
        run_cmd(12'd4094, 13'd4, 0, 0);   // address wrap
        run_cmd(12'd300,  13'd8, 1, 0);   // backpressure pattern
        run_cmd(12'd77,   13'd0, 0, 0);   // zero length
        run_cmd(12'd500,  13'd4, 0, 2);   // start while busy ignored
        run_cmd(12'd4090, 13'd13, 2, 0);  // random ready across wrap
        run_cmd(12'd1,    13'd1, 0, 0);   // single word

        // Reset in the middle of an 8-beat command after 2 beats
        push_expected(12'd200, 13'd8);
        start = 1'b1; base_addr = 12'd200; len = 13'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pops_before_reset", n_popped, 2);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_csbn", csbn, 1);
        chk("abort_raddr", raddr, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_m_last", m_last, 0);
        chk("abort_m_data", m_data, 0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_done_after_abort", done, 0);
            chk("no_read_after_abort", csbn, 1);
        end
        @(posedge clk); #1;
        run_cmd(12'd0, 13'd2, 0, 0);

        // Randomised commands
        for (int r = 0; r < 10; r++) begin
            logic [ADDR_W-1:0] rb;
            logic [ADDR_W:0]   rl;
            rb = ADDR_W'($urandom);
            rl = (ADDR_W + 1)'($urandom_range(0, 30));
            run_cmd(rb, rl, int'($urandom_range(0, 2)), 0);
        end

        // Full-depth command
        run_cmd(12'd2000, 13'd4096, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
